// File: rtl/fibonacci_pkg.sv
// Shared register map, control/status bit positions and engine state encoding.
// Byte-lane merge helper for the bus-writable registers.
package fibonacci_pkg;

    localparam logic [2:0] OFS_CTRL   = 3'd0;
    localparam logic [2:0] OFS_DIV    = 3'd1;
    localparam logic [2:0] OFS_LIMIT  = 3'd2;
    localparam logic [2:0] OFS_VALUE  = 3'd3;
    localparam logic [2:0] OFS_INDEX  = 3'd4;
    localparam logic [2:0] OFS_STATUS = 3'd5;

    localparam int CTRL_GO     = 0;
    localparam int CTRL_CLEAR  = 1;
    localparam int CTRL_IRQ_EN = 2;
    localparam int CTRL_OE_EN  = 3;

    localparam int ST_BUSY = 0;
    localparam int ST_DONE = 1;
    localparam int ST_OVF  = 2;

    typedef enum logic [1:0] {
        FSM_IDLE = 2'd0,
        FSM_RUN  = 2'd1,
        FSM_DONE = 2'd2
    } fsm_state_e;

    function automatic logic [31:0] lane_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  sel);
        logic [31:0] mask;
        for (int i = 0; i < 4; i++) begin
            mask[i*8 +: 8] = {8{sel[i]}};
        end
        return (old_val & ~mask) | (new_val & mask);
    endfunction

endpackage

// File: rtl/fib_engine.sv
// Fibonacci sequencer: a/b/INDEX datapath, step prescaler and run-control FSM.
// One term per DIV+1 cycles while running; DONE/OVF flags are sticky until W1C, GO or CLEAR.
module fib_engine
    import fibonacci_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             go,
    input  logic             clear,
    input  logic [DIV_W-1:0] div,
    input  logic [WIDTH-1:0] limit,
    input  logic             done_clr,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] value,
    output logic [WIDTH-1:0] index,
    output logic             busy,
    output logic             done,
    output logic             ovf
);

    fsm_state_e       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] value_q, value_d;
    logic [WIDTH-1:0] index_q, index_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH:0]   sum;

    assign sum = {1'b0, a_q} + {1'b0, b_q};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        value_d = value_q;
        index_d = index_q;
        cnt_d   = cnt_q;
        done_d  = done_q & ~done_clr;
        ovf_d   = ovf_q & ~ovf_clr;
        if (clear) begin
            state_d = FSM_IDLE;
            a_d     = '0;
            b_d     = '0;
            value_d = '0;
            index_d = '0;
            cnt_d   = '0;
            done_d  = 1'b0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                FSM_RUN: begin
                    if (index_q == limit) begin
                        state_d = FSM_DONE;
                        done_d  = 1'b1;
                    end else if (cnt_q >= div) begin
                        // >= so a DIV lowered mid-count still fires on the next compare
                        cnt_d   = '0;
                        value_d = b_q;
                        a_d     = b_q;
                        b_d     = sum[WIDTH-1:0];
                        index_d = index_q + WIDTH'(1);
                        if (sum[WIDTH]) begin
                            ovf_d   = 1'b1;
                            done_d  = 1'b1;
                            state_d = FSM_DONE;
                        end
                    end else begin
                        cnt_d = cnt_q + DIV_W'(1);
                    end
                end
                FSM_IDLE, FSM_DONE: begin
                    if (go) begin
                        state_d = FSM_RUN;
                        a_d     = '0;
                        b_d     = WIDTH'(1);
                        value_d = '0;
                        index_d = '0;
                        cnt_d   = '0;
                        done_d  = 1'b0;
                        ovf_d   = 1'b0;
                    end
                end
                default: state_d = FSM_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FSM_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            value_q <= '0;
            index_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            value_q <= value_d;
            index_q <= index_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    assign value = value_q;
    assign index = index_q;
    assign busy  = (state_q == FSM_RUN);
    assign done  = done_q;
    assign ovf   = ovf_q;

endmodule

// File: rtl/fibonacci_wb.sv
// Wishbone slave wrapper around fib_engine: register decode, byte-lane writes, IRQ and pads.
// Ack one cycle after a request is first seen, never two acks back to back; no wait states.
module fibonacci_wb
    import fibonacci_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIV_W = 16
) (
    input  logic        wb_clk_i,
    input  logic        resetb,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [15:0] io_out,
    output logic [15:0] io_oeb,
    output logic        irq_o
);

    logic             ack_q, ack_d;
    logic [31:0]      dat_q, dat_d;
    logic             irq_en_q, irq_en_d;
    logic             oe_en_q, oe_en_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [WIDTH-1:0] limit_q, limit_d;

    logic             req, wr_en, rd_en;
    logic [2:0]       ofs;
    logic [31:0]      ctrl_old, ctrl_new, div_new, limit_new, rdata;
    logic             go, clear, done_clr, ovf_clr;
    logic [WIDTH-1:0] eng_value, eng_index;
    logic [31:0]      value32, index32;
    logic             eng_busy, eng_done, eng_ovf;
    logic             unused_adr;

    assign req   = wbs_cyc_i & wbs_stb_i & ~ack_q;
    assign wr_en = req & wbs_we_i;
    assign rd_en = req & ~wbs_we_i;
    assign ofs   = wbs_adr_i[4:2];
    assign unused_adr = ^{wbs_adr_i[31:5], wbs_adr_i[1:0]};

    assign value32 = 32'(eng_value);
    assign index32 = 32'(eng_index);

    // GO/CLEAR and the W1C bits all live in byte lane 0
    assign go       = wr_en && (ofs == OFS_CTRL)   && wbs_sel_i[0] && wbs_dat_i[CTRL_GO];
    assign clear    = wr_en && (ofs == OFS_CTRL)   && wbs_sel_i[0] && wbs_dat_i[CTRL_CLEAR];
    assign done_clr = wr_en && (ofs == OFS_STATUS) && wbs_sel_i[0] && wbs_dat_i[ST_DONE];
    assign ovf_clr  = wr_en && (ofs == OFS_STATUS) && wbs_sel_i[0] && wbs_dat_i[ST_OVF];

    always_comb begin
        ctrl_old              = '0;
        ctrl_old[CTRL_IRQ_EN] = irq_en_q;
        ctrl_old[CTRL_OE_EN]  = oe_en_q;
        ctrl_new  = lane_merge(ctrl_old, wbs_dat_i, wbs_sel_i);
        div_new   = lane_merge(32'(div_q), wbs_dat_i, wbs_sel_i);
        limit_new = lane_merge(32'(limit_q), wbs_dat_i, wbs_sel_i);

        irq_en_d = irq_en_q;
        oe_en_d  = oe_en_q;
        div_d    = div_q;
        limit_d  = limit_q;
        if (wr_en) begin
            case (ofs)
                OFS_CTRL: begin
                    irq_en_d = ctrl_new[CTRL_IRQ_EN];
                    oe_en_d  = ctrl_new[CTRL_OE_EN];
                end
                OFS_DIV:   div_d   = DIV_W'(div_new);
                OFS_LIMIT: limit_d = WIDTH'(limit_new);
                default: ;
            endcase
        end
    end

    always_comb begin
        rdata = '0;
        case (ofs)
            OFS_CTRL: begin
                rdata[CTRL_IRQ_EN] = irq_en_q;
                rdata[CTRL_OE_EN]  = oe_en_q;
            end
            OFS_DIV:   rdata = 32'(div_q);
            OFS_LIMIT: rdata = 32'(limit_q);
            OFS_VALUE: rdata = value32;
            OFS_INDEX: rdata = index32;
            OFS_STATUS: begin
                rdata[ST_BUSY] = eng_busy;
                rdata[ST_DONE] = eng_done;
                rdata[ST_OVF]  = eng_ovf;
            end
            default: rdata = '0;
        endcase
        ack_d = req;
        dat_d = rd_en ? rdata : 32'd0;
    end

    always_ff @(posedge wb_clk_i or negedge resetb) begin
        if (!resetb) begin
            ack_q    <= 1'b0;
            dat_q    <= '0;
            irq_en_q <= 1'b0;
            oe_en_q  <= 1'b0;
            div_q    <= '0;
            limit_q  <= '0;
        end else begin
            ack_q    <= ack_d;
            dat_q    <= dat_d;
            irq_en_q <= irq_en_d;
            oe_en_q  <= oe_en_d;
            div_q    <= div_d;
            limit_q  <= limit_d;
        end
    end

    fib_engine #(
        .WIDTH (WIDTH),
        .DIV_W (DIV_W)
    ) u_engine (
        .clk      (wb_clk_i),
        .rst_n    (resetb),
        .go       (go),
        .clear    (clear),
        .div      (div_q),
        .limit    (limit_q),
        .done_clr (done_clr),
        .ovf_clr  (ovf_clr),
        .value    (eng_value),
        .index    (eng_index),
        .busy     (eng_busy),
        .done     (eng_done),
        .ovf      (eng_ovf)
    );

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign irq_o     = irq_en_q & eng_done;
    assign io_oeb    = {16{~oe_en_q}};
    assign io_out    = value32[15:0];

endmodule

// File: tb/tb_fibonacci_wb.sv
// Directed plus randomized bench for fibonacci_wb; expected values come from plain
// Fibonacci arithmetic and the DIV/LIMIT timing rules, checked every cycle of each run.
module tb_fibonacci_wb;

    localparam logic [31:0] A_CTRL   = 32'h00;
    localparam logic [31:0] A_DIV    = 32'h04;
    localparam logic [31:0] A_LIMIT  = 32'h08;
    localparam logic [31:0] A_VALUE  = 32'h0C;
    localparam logic [31:0] A_INDEX  = 32'h10;
    localparam logic [31:0] A_STATUS = 32'h14;

    logic        clk = 1'b0;
    logic        resetb = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = '0, wdat = '0;
    logic        ack;
    logic [31:0] rdat;
    logic [15:0] io_out, io_oeb;
    logic        irq;

    int checks = 0;
    int failures = 0;
    int cyc_cnt = 0;
    int last_cyc = 0;

    fibonacci_wb dut (
        .wb_clk_i  (clk),
        .resetb    (resetb),
        .wbs_cyc_i (cyc),
        .wbs_stb_i (stb),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_adr_i (adr),
        .wbs_dat_i (wdat),
        .wbs_ack_o (ack),
        .wbs_dat_o (rdat),
        .io_out    (io_out),
        .io_oeb    (io_oeb),
        .irq_o     (irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; wdat = d; sel = s;
        @(posedge clk);
        #1;
        check("wr_ack", {31'd0, ack}, 32'd1);
        last_cyc = cyc_cnt;
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a; sel = 4'hF;
        @(posedge clk);
        #1;
        check("rd_ack", {31'd0, ack}, 32'd1);
        d = rdat;
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0;
    endtask

    function automatic longint unsigned fib(input int k);
        longint unsigned x = 0, y = 1, t;
        for (int i = 0; i < k; i++) begin
            t = x + y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Run length: LIMIT terms, or fewer if the next b term would not fit in 32 bits.
    function automatic void model_stop(input int lim, output int stop, output bit ovf);
        stop = lim;
        ovf  = 1'b0;
        for (int k = 0; k < lim; k++) begin
            if (fib(k + 2) > 64'hFFFF_FFFF) begin
                stop = k + 1;
                ovf  = 1'b1;
                break;
            end
        end
    endfunction

    task automatic run_and_check(input int d, input int lim, output int done_at,
                                 output logic [31:0] idx, output logic [31:0] val,
                                 output logic [31:0] st);
        int  stop, tdone, t, nsteps, t0;
        bit  ovf;
        bus_write(A_DIV, 32'(d), 4'hF);
        bus_write(A_LIMIT, 32'(lim), 4'hF);
        bus_write(A_CTRL, 32'hD, 4'hF);
        t0 = last_cyc;
        model_stop(lim, stop, ovf);
        tdone   = ovf ? stop * (d + 1) : lim * (d + 1) + 1;
        done_at = -1;
        while ((cyc_cnt - t0) <= tdone + 2) begin
            t      = cyc_cnt - t0;
            nsteps = t / (d + 1);
            if (nsteps > stop) nsteps = stop;
            check("run_io_out", {16'd0, io_out}, 32'(fib(nsteps) & 64'hFFFF));
            check("run_irq", {31'd0, irq}, {31'd0, (t >= tdone)});
            if (irq && done_at < 0) done_at = t;
            @(negedge clk);
        end
        bus_read(A_INDEX, idx);
        check("run_index", idx, 32'(stop));
        bus_read(A_VALUE, val);
        check("run_value", val, 32'(fib(stop)));
        bus_read(A_STATUS, st);
        check("run_status", st, {29'd0, ovf, 1'b1, 1'b0});
    endtask

    initial begin
        logic [31:0] r, vi, vv, vs;
        logic        a1, a2, a3;
        int          dn, t0, rd, rl;

        // reset held
        repeat (3) @(negedge clk);
        check("rst_ack", {31'd0, ack}, 32'd0);
        check("rst_dat", rdat, 32'd0);
        check("rst_oeb", {16'd0, io_oeb}, 32'hFFFF);
        check("rst_io_out", {16'd0, io_out}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        resetb = 1'b1;

        for (int i = 0; i < 6; i++) begin
            bus_read(32'(i * 4), r);
            check("rst_reg", r, 32'd0);
        end

        // byte lanes, unmapped offsets, GO needs lane 0
        bus_write(A_DIV, 32'hFFFF_FF03, 4'b0001);
        bus_read(A_DIV, r);
        check("sel_div", r, 32'h0000_0003);
        bus_write(A_LIMIT, 32'h1234_5678, 4'b1100);
        bus_read(A_LIMIT, r);
        check("sel_limit", r, 32'h1234_0000);
        bus_write(A_CTRL, 32'h0000_0001, 4'b0010);
        bus_read(A_STATUS, r);
        check("go_no_lane0", r, 32'd0);
        bus_write(32'h18, 32'hFFFF_FFFF, 4'hF);
        bus_read(32'h18, r);
        check("unmapped_18", r, 32'd0);
        bus_read(32'h1C, r);
        check("unmapped_1c", r, 32'd0);

        // held strobe: ack, gap, ack
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = A_LIMIT; sel = 4'hF;
        @(posedge clk); #1; a1 = ack;
        @(posedge clk); #1; a2 = ack;
        @(posedge clk); #1; a3 = ack;
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0;
        check("held_ack1", {31'd0, a1}, 32'd1);
        check("held_ack2", {31'd0, a2}, 32'd0);
        check("held_ack3", {31'd0, a3}, 32'd1);

        // normal run
        run_and_check(0, 10, dn, vi, vv, vs);
        check("norm_done_cyc", 32'(dn), 32'd11);
        check("norm_value", vv, 32'd55);
        check("norm_index", vi, 32'd10);
        check("norm_status", vs, 32'h2);

        // LIMIT==0
        run_and_check(2, 0, dn, vi, vv, vs);
        check("lim0_done_cyc", 32'(dn), 32'd1);
        check("lim0_value", vv, 32'd0);

        // overflow run, then W1C of OVF alone
        run_and_check(0, 60, dn, vi, vv, vs);
        check("ovf_index", vi, 32'd47);
        check("ovf_value", vv, 32'hB119_24E1);
        check("ovf_status", vs, 32'h6);
        bus_write(A_STATUS, 32'h4, 4'hF);
        bus_read(A_STATUS, r);
        check("ovf_w1c", r, 32'h2);

        // prescaler
        run_and_check(3, 4, dn, vi, vv, vs);
        check("div3_done_cyc", 32'(dn), 32'd17);
        check("div3_value", vv, 32'd3);

        // IRQ and pads
        run_and_check(0, 7, dn, vi, vv, vs);
        check("pad_irq", {31'd0, irq}, 32'd1);
        check("pad_io_out", {16'd0, io_out}, 32'h000D);
        check("pad_oeb", {16'd0, io_oeb}, 32'h0000);
        bus_write(A_STATUS, 32'h2, 4'hF);
        #1;
        check("w1c_irq", {31'd0, irq}, 32'd0);
        bus_read(A_STATUS, r);
        check("w1c_status", r, 32'd0);

        // GO while busy is ignored
        bus_write(A_DIV, 32'd1, 4'hF);
        bus_write(A_LIMIT, 32'd12, 4'hF);
        bus_write(A_CTRL, 32'h5, 4'hF);
        t0 = last_cyc;
        repeat (4) @(negedge clk);
        bus_write(A_CTRL, 32'h5, 4'hF);
        for (int i = 0; i < 100 && !irq; i++) @(negedge clk);
        dn = irq ? (cyc_cnt - t0) : -1;
        check("busy_go_done_cyc", 32'(dn), 32'd25);
        bus_read(A_VALUE, r);
        check("busy_go_value", r, 32'd144);

        // CLEAR mid-run (DIV=0: every RUN cycle is a step)
        bus_write(A_DIV, 32'd0, 4'hF);
        bus_write(A_LIMIT, 32'd30, 4'hF);
        bus_write(A_CTRL, 32'h5, 4'hF);
        repeat ($urandom_range(2, 15)) @(negedge clk);
        bus_write(A_CTRL, 32'h2, 4'h1);
        bus_read(A_VALUE, r);
        check("clr_value", r, 32'd0);
        bus_read(A_INDEX, r);
        check("clr_index", r, 32'd0);
        bus_read(A_STATUS, r);
        check("clr_status", r, 32'd0);
        repeat (40) @(negedge clk);
        bus_read(A_STATUS, r);
        check("clr_stays_idle", r, 32'd0);

        // randomized runs
        for (int n = 0; n < 6; n++) begin
            rd = $urandom_range(0, 3);
            rl = $urandom_range(0, 55);
            run_and_check(rd, rl, dn, vi, vv, vs);
        end

        // reset mid-run aborts, needs a fresh GO
        bus_write(A_DIV, 32'd0, 4'hF);
        bus_write(A_LIMIT, 32'd40, 4'hF);
        bus_write(A_CTRL, 32'hD, 4'hF);
        repeat (5) @(negedge clk);
        resetb = 1'b0;
        @(negedge clk);
        check("mrst_io_out", {16'd0, io_out}, 32'd0);
        check("mrst_oeb", {16'd0, io_oeb}, 32'hFFFF);
        check("mrst_irq", {31'd0, irq}, 32'd0);
        resetb = 1'b1;
        repeat (50) @(negedge clk);
        bus_read(A_STATUS, r);
        check("mrst_status", r, 32'd0);
        bus_read(A_INDEX, r);
        check("mrst_index", r, 32'd0);
        bus_read(A_LIMIT, r);
        check("mrst_limit", r, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
